// File: rtl/hbridge_pwm_array.sv
// hbridge_pwm_array: multi-channel H-bridge driver with edge-aligned PWM
// enables, a shared prescaler/period counter, glitch-free duty updates at
// period boundaries and a forced-off dead-time sequence on every reversal.
// Optional build macro: HBRIDGE_SOFTSTART_EN (duty ramps by 1 LSB per period
// toward the request and restarts from zero after each reversal).
module hbridge_pwm_array #(
   parameter int CHANNELS    = 2,
   parameter int RES         = 8,
   parameter int PRESCALE    = 1,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CHANNELS*RES-1:0] speed,
   input  logic [CHANNELS-1:0]     direction_control,
   output logic [CHANNELS-1:0]     motor_enable,
   output logic [CHANNELS-1:0]     motor_direction,
   output logic [CHANNELS-1:0]     reversing
);

   // Last counter value of a period: 2^RES-2, so a period is 2^RES-1 ticks.
   localparam logic [RES-1:0] CNT_LAST  = {{(RES-1){1'b1}}, 1'b0};
   localparam logic [15:0]    PRE_LAST  = 16'(PRESCALE - 1);
   localparam logic [15:0]    DEAD_INIT = 16'(DEAD_CYCLES - 1);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_DEAD = 2'd1;
   localparam logic [1:0] ST_SYNC = 2'd2;

   logic [15:0]    pre_q;
   logic [RES-1:0] cnt_q;
   logic           tick;
   logic           wrap;

   assign tick = (pre_q == PRE_LAST);
   // Period boundary: duty latch and SYNC->RUN release share this strobe.
   assign wrap = tick && (cnt_q == CNT_LAST);

   // Shared prescaler producing one PWM tick every PRESCALE clocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + 16'd1;
      end
   end

   // Shared period counter, 0..2^RES-2, advancing on tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (tick) begin
         if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [1:0]     state_q, state_d;
         logic [15:0]    dead_q, dead_d;
         logic [RES-1:0] duty_q, duty_d;
         logic           dir_q, dir_d;
         logic           en_q, en_d;
         logic           rev_q, rev_d;
         logic [RES-1:0] spd;
         logic           req;

         assign spd = speed[gi*RES +: RES];
         assign req = direction_control[gi] ^ dir_q;

         // Next-state logic: duty latch, reversal FSM and PWM compare.
         always_comb begin
            state_d = state_q;
            dead_d  = dead_q;
            duty_d  = duty_q;
            dir_d   = dir_q;

`ifdef HBRIDGE_SOFTSTART_EN
            if (wrap) begin
               if (duty_q < spd) begin
                  duty_d = duty_q + 1'b1;
               end else if (duty_q > spd) begin
                  duty_d = duty_q - 1'b1;
               end
            end
`else
            if (wrap) begin
               duty_d = spd;
            end
`endif

            case (state_q)
               ST_RUN: begin
                  if (req) begin
                     state_d = ST_DEAD;
                     dead_d  = DEAD_INIT;
                  end
               end
               ST_DEAD: begin
                  // Direction is sampled only once the dead time has elapsed,
                  // so a request withdrawn mid-dead-time leaves the pin alone.
                  if (dead_q == 16'd0) begin
                     dir_d   = direction_control[gi];
                     state_d = ST_SYNC;
                  end else begin
                     dead_d = dead_q - 16'd1;
                  end
               end
               ST_SYNC: begin
                  if (req) begin
                     state_d = ST_DEAD;
                     dead_d  = DEAD_INIT;
                  end else if (wrap) begin
                     state_d = ST_RUN;
                  end
               end
               default: begin
                  state_d = ST_RUN;
               end
            endcase

`ifdef HBRIDGE_SOFTSTART_EN
            if (state_d == ST_DEAD && state_q != ST_DEAD) begin
               duty_d = '0;
            end
`endif

            // Masking with req drops the enable on the same edge the FSM
            // leaves RUN, so the full dead time is spent with the bridge off.
            en_d  = (state_q == ST_RUN) && !req && (duty_q > cnt_q);
            rev_d = (state_d != ST_RUN);
         end

         // Per-channel state and registered bridge outputs.
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= ST_RUN;
               dead_q  <= '0;
               duty_q  <= '0;
               dir_q   <= 1'b0;
               en_q    <= 1'b0;
               rev_q   <= 1'b0;
            end else begin
               state_q <= state_d;
               dead_q  <= dead_d;
               duty_q  <= duty_d;
               dir_q   <= dir_d;
               en_q    <= en_d;
               rev_q   <= rev_d;
            end
         end

         assign motor_enable[gi]    = en_q;
         assign motor_direction[gi] = dir_q;
         assign reversing[gi]       = rev_q;
      end
   endgenerate

endmodule

// File: tb/tb_hbridge_pwm_array.sv
// Directed bench for hbridge_pwm_array: duty timing, boundary latching,
// reversal dead time, aborted reversal, reset mid-pulse and prescaling.
module tb_hbridge_pwm_array;

   logic        clk;
   logic        rst;
   logic [15:0] speed;
   logic [1:0]  dc;
   logic [1:0]  en, dir, rev;

   logic [3:0]  speed2;
   logic        dc2;
   logic        en2, dir2, rev2;

   int n_tests = 0;
   int n_fail  = 0;
   int mcnt    = 0;

   hbridge_pwm_array #(.CHANNELS(2), .RES(8), .PRESCALE(1), .DEAD_CYCLES(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .speed             (speed),
      .direction_control (dc),
      .motor_enable      (en),
      .motor_direction   (dir),
      .reversing         (rev)
   );

   hbridge_pwm_array #(.CHANNELS(1), .RES(4), .PRESCALE(3), .DEAD_CYCLES(2)) dut2 (
      .clk               (clk),
      .rst               (rst),
      .speed             (speed2),
      .direction_control (dc2),
      .motor_enable      (en2),
      .motor_direction   (dir2),
      .reversing         (rev2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference period position for the 8-bit, prescale-1 instance.
   always @(posedge clk) begin
      if (rst) mcnt <= 0;
      else     mcnt <= (mcnt == 254) ? 0 : mcnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_boundary();
      for (int i = 0; i < 300; i++) begin
         if (mcnt == 0) return;
         step();
      end
      n_tests++;
      n_fail++;
      $display("FAIL boundary_timeout: got mcnt %0d expected 0", mcnt);
   endtask

   // Runs one full period from a boundary; optionally changes speed mid-period.
   task automatic period_check(input string tag, input int exp0, input int exp1,
                               input int chg_at, input logic [15:0] chg_spd);
      int   hi0 = 0;
      int   hi1 = 0;
      logic first0 = 1'b0;
      for (int j = 1; j <= 255; j++) begin
         step();
         if (j == 1) first0 = en[0];
         if (en[0]) hi0++;
         if (en[1]) hi1++;
         if (j == chg_at) speed = chg_spd;
      end
      check_eq({tag, "_hi0"}, hi0, exp0);
      check_eq({tag, "_hi1"}, hi1, exp1);
      check_eq({tag, "_first0"}, {31'd0, first0}, {31'd0, (exp0 > 0)});
      $display("[TB] %s: ch0 high %0d/%0d, ch1 high %0d/%0d", tag, hi0, exp0, hi1, exp1);
   endtask

   initial begin
      int   hi;
      logic saw;
      rst    = 1'b1;
      speed  = 16'd0;
      dc     = 2'b00;
      speed2 = 4'd5;
      dc2    = 1'b0;
      step(); step(); step();
      check_eq("rst_en",  {30'd0, en},  0);
      check_eq("rst_dir", {30'd0, dir}, 0);
      check_eq("rst_rev", {30'd0, rev}, 0);
      check_eq("rst_dut2", {29'd0, en2, dir2, rev2}, 0);
      rst = 1'b0;

`ifdef HBRIDGE_SOFTSTART_EN
      speed = {8'd0, 8'd5};
      period_check("ss0", 0, 0, 0, speed);
      period_check("ss1", 1, 0, 0, speed);
      period_check("ss2", 2, 0, 0, speed);
      period_check("ss3", 3, 0, 0, speed);
      period_check("ss4", 4, 0, 0, speed);
      period_check("ss5", 5, 0, 0, speed);
      period_check("ss6", 5, 0, 0, speed);
`else
      // Duty patterns and mid-period changes.
      speed = {8'd50, 8'd128};
      period_check("p0_zero", 0,   0,  0,   speed);
      period_check("p1_128",  128, 50, 100, {8'd50, 8'd0});
      period_check("p2_0",    0,   50, 10,  {8'd50, 8'd255});
      period_check("p3_255",  255, 50, 200, {8'd50, 8'd64});
      period_check("p4_64",   64,  50, 100, {8'd50, 8'd192});
      period_check("p5_192",  192, 50, 5,   {8'd50, 8'd200});
      period_check("p6_200",  200, 50, 0,   speed);

      // Reversal 0->1 at speed 200.
      for (int i = 0; i < 10; i++) step();
      check_eq("rev_pre_en", {31'd0, en[0]}, 1);
      dc[0] = 1'b1;
      step();
      check_eq("rev_en_off", {31'd0, en[0]}, 0);
      check_eq("rev_flag",   {31'd0, rev[0]}, 1);
      saw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (en[0]) saw = 1'b1;
      end
      check_eq("rev_dir_hold", {31'd0, dir[0]}, 0);
      step();
      check_eq("rev_dir_flip", {31'd0, dir[0]}, 1);
      for (int i = 0; i < 300; i++) begin
         if (mcnt == 254) break;
         step();
         if (en[0]) saw = 1'b1;
      end
      check_eq("rev_en_quiet", {31'd0, saw}, 0);
      check_eq("rev_sync", {31'd0, rev[0]}, 1);
      step();
      check_eq("rev_release", {31'd0, rev[0]}, 0);
      period_check("post_rev", 200, 50, 0, speed);

      // Withdrawn reversal 1->0->1 inside the dead time.
      for (int i = 0; i < 10; i++) step();
      dc[0] = 1'b0;
      step(); step(); step();
      dc[0] = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dir[0] != 1'b1 || en[0]) saw = 1'b1;
      end
      check_eq("abort_dir_en", {31'd0, saw}, 0);
      check_eq("abort_rev", {31'd0, rev[0]}, 1);
      for (int i = 0; i < 300; i++) begin
         if (mcnt == 254) break;
         step();
         if (en[0]) saw = 1'b1;
      end
      check_eq("abort_rev_sync", {31'd0, rev[0]}, 1);
      check_eq("abort_en_quiet", {31'd0, saw}, 0);
      step();
      check_eq("abort_release", {31'd0, rev[0]}, 0);
      period_check("post_abort", 200, 50, 50, {8'd50, 8'd100});
      period_check("pre_rst", 100, 50, 0, speed);

      // Reset mid-pulse with direction_control[0] held at 1.
      for (int i = 0; i < 20; i++) step();
      check_eq("mid_en_pre", {30'd0, en}, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("mid_rst_en",  {30'd0, en},  0);
      check_eq("mid_rst_dir", {30'd0, dir}, 0);
      check_eq("mid_rst_rev", {30'd0, rev}, 0);
      step();
      check_eq("mid_rev_ch", {30'd0, rev}, 1);
      to_boundary();
      check_eq("mid_dir_done", {30'd0, dir}, 1);
      check_eq("mid_rev_done", {30'd0, rev}, 0);
      period_check("rst_resume", 100, 50, 0, speed);

      // Prescaled 4-bit instance: 15 ticks x 3 clks, duty 5 -> 15 high clks.
      hi = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (en2) hi++;
      end
      check_eq("ps_high", hi, 15);
      $display("[TB] prescale window: high %0d/15", hi);
      dc2 = 1'b1;
      step();
      check_eq("ps_rev_en", {31'd0, en2}, 0);
      step();
      check_eq("ps_dir_hold", {31'd0, dir2}, 0);
      step();
      check_eq("ps_dir_flip", {31'd0, dir2}, 1);
      for (int i = 0; i < 100; i++) step();
      hi = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (en2) hi++;
      end
      check_eq("ps_high_after", hi, 15);
      check_eq("ps_rev_after", {31'd0, rev2}, 0);
      $display("[TB] prescale after reversal: high %0d/15", hi);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
